// File: rtl/ma_ctrl_pkg.sv
// ma_ctrl_pkg
// Shared definitions for the moving-average scheduler: controller state
// encoding, filter-select encodings and the select-to-window mapping.
package ma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_GAP_WAIT  = 3'd3,
    ST_CLEAR     = 3'd4
  } state_e;

  // Filter-select encodings as seen on cfg_sel / avg_sel.
  localparam logic [1:0] SEL_2   = 2'b00;
  localparam logic [1:0] SEL_4   = 2'b01;
  localparam logic [1:0] SEL_8   = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  // Warm-up count saturates at the largest window.
  localparam logic [3:0] WARMUP_MAX = 4'd8;

  // Window length for a select value. SEL_BAD is never latched into
  // avg_sel, so its mapping only has to be something harmless.
  function automatic logic [3:0] window_size(input logic [1:0] sel);
    logic [3:0] w;
    case (sel)
      SEL_2:   w = 4'd2;
      SEL_4:   w = 4'd4;
      default: w = 4'd8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ma_warmup_tracker.sv
// ma_warmup_tracker
// Counts results since the last history clear (saturating at 8) and flags
// whether the averager window is full, counting the result being issued.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - restart the count (history is being cleared)
//   inc_i       - a result is being forwarded this cycle
//   sel_i       - current filter select, sets the window length
//   settled_o   - registered; valid alongside the forwarded result
module ma_warmup_tracker
  import ma_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [1:0] sel_i,
  output logic       settled_o
);

  logic [3:0] count_q, count_d, count_inc;
  logic       settled_q, settled_d;

  always_comb begin
    count_inc = (count_q >= WARMUP_MAX) ? WARMUP_MAX : count_q + 4'd1;
    count_d   = count_q;
    settled_d = settled_q;
    if (clr_i) begin
      count_d   = 4'd0;
      settled_d = 1'b0;
    end else if (inc_i) begin
      count_d   = count_inc;
      // Compare with the incremented count so the window-th result is
      // already marked settled.
      settled_d = (count_inc >= window_size(sel_i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 4'd0;
      settled_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      settled_q <= settled_d;
    end
  end

  assign settled_o = settled_q;

endmodule

// File: rtl/ma_sample_scheduler.sv
// ma_sample_scheduler
// Sequences the moving-average datapath: accepts upstream samples, issues
// each as a single-cycle strobe, waits (bounded) for the averager's result
// and forwards it, enforcing a gap before the next acceptance. Also runs
// filter-size reconfiguration (history clear + ack) and error reporting.
// Ports:
//   s_data/s_valid/s_ready  - upstream sample handshake
//   cfg_sel/cfg_req         - requested filter size, level request
//   cfg_ack/cfg_err         - request consumed pulse, illegal-size pulse
//   avg_data/avg_strobe/avg_sel/avg_clear - averager controls
//   avg_result/avg_done     - averager output and its strobe
//   m_data/m_valid/m_settled - forwarded result and window-full flag
//   err_timeout             - sticky response-timeout flag
module ma_sample_scheduler
  import ma_ctrl_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int GAP          = 1,
  parameter int RESP_TIMEOUT = 8,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        cfg_sel,
  input  logic              cfg_req,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_strobe,
  output logic [1:0]        avg_sel,
  output logic              avg_clear,
  input  logic [DATA_W-1:0] avg_result,
  input  logic              avg_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_settled,
  output logic              err_timeout
);

  // Terminal values for the shared cycle counter in each timed state.
  localparam logic [7:0] TO_LAST  = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [DATA_W-1:0]   avg_data_q;
  logic                avg_strobe_q;
  logic [1:0]          avg_sel_q;
  logic                avg_clear_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                m_valid_q;
  logic                cfg_ack_q;
  logic                cfg_err_q;
  logic                err_timeout_q;
  logic                resp_hit;

  // A pending config request blocks sample acceptance.
  assign s_ready  = (state_q == ST_IDLE) && !cfg_req;
  assign resp_hit = (state_q == ST_WAIT_RESP) && avg_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      avg_data_q    <= '0;
      avg_strobe_q  <= 1'b0;
      avg_sel_q     <= SEL_2;
      avg_clear_q   <= 1'b0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      cfg_ack_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      avg_strobe_q <= 1'b0;
      m_valid_q    <= 1'b0;
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // cfg_req is still high in the cycle its ack is visible; ignore
          // it then so one request is never consumed twice.
          if (cfg_req && !cfg_ack_q) begin
            if (cfg_sel == SEL_BAD) begin
              cfg_ack_q <= 1'b1;
              cfg_err_q <= 1'b1;
            end else begin
              avg_sel_q   <= cfg_sel;
              avg_clear_q <= 1'b1;
              cnt_q       <= 8'd0;
              state_q     <= ST_CLEAR;
            end
          end else if (s_valid && s_ready) begin
            avg_data_q   <= s_data;
            avg_strobe_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= 8'd0;
          state_q <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          // A response in the expiring cycle still wins over the timeout.
          if (avg_done) begin
            m_data_q  <= avg_result;
            m_valid_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= (GAP == 0) ? ST_IDLE : ST_GAP_WAIT;
          end else if (cnt_q == TO_LAST) begin
            err_timeout_q <= 1'b1;
            cnt_q         <= 8'd0;
            state_q       <= (GAP == 0) ? ST_IDLE : ST_GAP_WAIT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_GAP_WAIT: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            avg_clear_q <= 1'b0;
            cfg_ack_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ma_warmup_tracker u_warmup (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == ST_CLEAR),
    .inc_i     (resp_hit),
    .sel_i     (avg_sel_q),
    .settled_o (m_settled)
  );

  assign avg_data    = avg_data_q;
  assign avg_strobe  = avg_strobe_q;
  assign avg_sel     = avg_sel_q;
  assign avg_clear   = avg_clear_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign cfg_ack     = cfg_ack_q;
  assign cfg_err     = cfg_err_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ma_sample_scheduler.sv
// tb_ma_sample_scheduler
// Directed bench: an averager model answers strobes (history latched on the
// strobe edge, result strobe one cycle later); a separate reference computes
// expected results at acceptance and queues them for the m_valid monitor.
module tb_ma_sample_scheduler;
  import ma_ctrl_pkg::*;

  localparam int DATA_W = 10;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              settled;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [1:0]        cfg_sel;
  logic              cfg_req;
  logic              cfg_ack;
  logic              cfg_err;
  logic [DATA_W-1:0] avg_data;
  logic              avg_strobe;
  logic [1:0]        avg_sel;
  logic              avg_clear;
  logic [DATA_W-1:0] mdl_result;
  logic              mdl_done;
  logic              inj_done;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_settled;
  logic              err_timeout;

  always #5 clk = ~clk;

  ma_sample_scheduler #(
    .DATA_W(DATA_W), .GAP(1), .RESP_TIMEOUT(8), .CLEAR_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_sel    (cfg_sel),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .avg_data   (avg_data),
    .avg_strobe (avg_strobe),
    .avg_sel    (avg_sel),
    .avg_clear  (avg_clear),
    .avg_result (mdl_result),
    .avg_done   (mdl_done | inj_done),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_settled  (m_settled),
    .err_timeout(err_timeout)
  );

  // ---------------- averager model ----------------
  logic [DATA_W-1:0] hist [8];
  logic              st_v;
  logic [DATA_W-1:0] st_res;
  logic [DATA_W-1:0] mdl_avg;
  logic              silent;

  always_comb begin
    int n;
    int sum;
    n   = int'(window_size(avg_sel));
    sum = int'(avg_data);
    for (int i = 0; i < 7; i++) if (i < n - 1) sum += int'(hist[i]);
    mdl_avg = DATA_W'(sum / n);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
      st_v       <= 1'b0;
      st_res     <= '0;
      mdl_done   <= 1'b0;
      mdl_result <= '0;
    end else begin
      mdl_done   <= st_v;
      mdl_result <= st_res;
      st_v       <= avg_strobe & ~silent;
      if (avg_clear) begin
        for (int i = 0; i < 8; i++) hist[i] <= '0;
      end else if (avg_strobe && !silent) begin
        for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= avg_data;
        st_res  <= mdl_avg;
      end
    end
  end

  // ---------------- reference + scoreboard ----------------
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mv_count = 0;
  int   strobe_dbl = 0;
  logic prev_strobe = 1'b0;
  int   ref_hist[$];
  int   ref_cnt = 0;
  logic [1:0] ref_sel = 2'b00;
  exp_t exp_q[$];
  logic [DATA_W-1:0] log_data[$];
  logic              log_set[$];
  int   acc_cyc[$];
  int   stim_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    ref_hist.delete();
    ref_cnt = 0;
  endtask

  task automatic ref_accept(input logic [DATA_W-1:0] d);
    int   w;
    int   sum;
    exp_t e;
    ref_hist.push_front(int'(d));
    if (ref_hist.size() > 8) void'(ref_hist.pop_back());
    w = (ref_sel == 2'b00) ? 2 : (ref_sel == 2'b01) ? 4 : 8;
    sum = 0;
    for (int i = 0; i < w && i < ref_hist.size(); i++) sum += ref_hist[i];
    if (ref_cnt < 8) ref_cnt++;
    e.data    = DATA_W'(sum / w);
    e.settled = (ref_cnt >= w);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (avg_strobe && prev_strobe) strobe_dbl++;
      prev_strobe = avg_strobe;
      if (m_valid) begin
        exp_t e;
        mv_count++;
        log_data.push_back(m_data);
        log_set.push_back(m_settled);
        check("m_valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_settled", m_settled, e.settled);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check(tag, {avg_data, avg_strobe, avg_sel, avg_clear, m_data, m_valid,
                m_settled, cfg_ack, cfg_err, err_timeout}, 0);
    check({tag, "_s_ready"}, s_ready, 1);
  endtask

  // Sends stim_q back to back with s_valid held high throughout.
  task automatic send_stream();
    int d;
    int waited;
    acc_cyc.delete();
    while (stim_q.size() > 0) begin
      d       = stim_q.pop_front();
      s_data  = DATA_W'(d);
      s_valid = 1'b1;
      waited  = 0;
      while (!s_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("s_ready_within_bound", s_ready, 1);
      if (!s_ready) break;
      acc_cyc.push_back(cyc);
      ref_accept(DATA_W'(d));
      @(negedge clk);
      check("avg_strobe_after_accept", avg_strobe, 1);
      check("avg_data", avg_data, d);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() > 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("drain_results", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [1:0] sel);
    int   clr_len = 0;
    int   waited = 0;
    logic prev_clear = 1'b0;
    logic legal;
    logic [1:0] exp_sel;
    legal   = (sel != 2'b11);
    exp_sel = legal ? sel : ref_sel;
    cfg_sel = sel;
    cfg_req = 1'b1;
    do begin
      prev_clear = avg_clear;
      @(negedge clk);
      waited++;
      if (avg_clear) clr_len++;
    end while (!cfg_ack && waited < 60);
    check("cfg_ack_seen", cfg_ack, 1);
    check("cfg_err", cfg_err, !legal);
    check("clear_len", clr_len, legal ? 2 : 0);
    check("clear_then_ack", prev_clear, legal);
    check("clear_low_at_ack", avg_clear, 0);
    check("avg_sel", avg_sel, exp_sel);
    cfg_req = 1'b0;
    if (legal) begin
      ref_sel = sel;
      ref_clear();
    end
    @(negedge clk);
    check("cfg_ack_one_cycle", cfg_ack, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int mv_before;
    s_valid  = 1'b0;
    s_data   = '0;
    cfg_req  = 1'b0;
    cfg_sel  = 2'b00;
    silent   = 1'b0;
    inj_done = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse through a size-2 window, continuous s_valid.
    for (int i = 0; i < 10; i++) stim_q.push_back(0);
    stim_q.push_back(1023);
    for (int i = 0; i < 4; i++) stim_q.push_back(0);
    log_data.delete();
    log_set.delete();
    send_stream();
    drain();
    check("accept_count", acc_cyc.size(), 15);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("accept_period", acc_cyc[i] - acc_cyc[i-1], 5);
    check("impulse_result", log_data[10], 511);
    check("after_impulse_result", log_data[11], 511);
    check("two_after_impulse", log_data[12], 0);
    check("settled_first", log_set[0], 0);
    check("settled_second", log_set[1], 1);

    // Reconfigure to size 8 while a sample is in flight.
    stim_q.push_back(100);
    stim_q.push_back(200);
    send_stream();
    do_cfg(2'b10);
    check("scoreboard_after_cfg", exp_q.size(), 0);
    log_data.delete();
    log_set.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(i * 10);
    send_stream();
    drain();
    for (int i = 0; i < 7; i++) check("size8_not_settled", log_set[i], 0);
    check("size8_settled_8th", log_set[7], 1);

    // Illegal select: ack + err, no clear, select unchanged.
    do_cfg(2'b11);

    // Silent averager: timeout after 8 WAIT_RESP cycles.
    silent    = 1'b1;
    mv_before = mv_count;
    s_data    = 10'd55;
    s_valid   = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("silent_accept", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    k = 1;
    while (!err_timeout && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycle", k, 10);
    check("s_ready_during_gap", s_ready, 0);
    @(negedge clk);
    check("s_ready_after_gap", s_ready, 1);
    check("no_m_valid_on_timeout", mv_count, mv_before);
    silent = 1'b0;
    stim_q.push_back(300);
    send_stream();
    drain();
    check("err_timeout_sticky", err_timeout, 1);

    // Reset during WAIT_RESP, then a late averager strobe.
    mv_before = mv_count;
    s_data    = 10'd77;
    s_valid   = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    ref_sel = 2'b00;
    ref_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (4) @(negedge clk);
    check("no_m_valid_after_reset", mv_count, mv_before);

    check("strobe_never_back_to_back", strobe_dbl, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_sample_scheduler.md
# ma_sample_scheduler

Controller that sits in front of the moving-average datapath and sequences it. It accepts samples on a valid/ready handshake and issues each to the averager as a single-cycle strobe with enforced spacing. It waits for the averager's output strobe, then forwards the result. It also owns filter-size reconfiguration: a clear sequence, history warm-up tracking, and timeout/illegal-config error reporting.

## Interface
- DATA_W, 10, sample and result width
- GAP, 1, minimum idle cycles between response receipt and next sample acceptance (0..15)
- RESP_TIMEOUT, 8, cycles to wait for averager strobe before abandoning a sample (1..255)
- CLEAR_CYCLES, 2, cycles avg_clear is held during reconfiguration (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- s_data  in  DATA_W  upstream sample
- s_valid  in  1  upstream sample valid
- s_ready  out  1  scheduler can accept a sample
- cfg_sel  in  2  requested filter size: 00=2, 01=4, 10=8, 11=illegal
- cfg_req  in  1  level request to apply cfg_sel
- cfg_ack  out  1  one-cycle pulse: request consumed
- cfg_err  out  1  one-cycle pulse with cfg_ack when cfg_sel=11
- avg_data  out  DATA_W  sample to averager data input
- avg_strobe  out  1  averager strobe input
- avg_sel  out  2  averager filter select
- avg_clear  out  1  averager history clear
- avg_result  in  DATA_W  averager output
- avg_done  in  1  averager output strobe
- m_data  out  DATA_W  forwarded result
- m_valid  out  1  one-cycle pulse per result
- m_settled  out  1  result is based on a full window since the last clear
- err_timeout  out  1  sticky; set on response timeout, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_RESP, GAP_WAIT, CLEAR.
- IDLE: s_ready = 1 when cfg_req = 0. s_ready is combinational from state and cfg_req.
  - cfg_req = 1 has priority and s_ready = 0.
  - For legal cfg_sel: latch it into avg_sel and go to CLEAR.
  - For cfg_sel = 11: pulse cfg_ack and cfg_err, stay in IDLE, leave avg_sel unchanged.
  - s_valid & s_ready: latch s_data into avg_data and go to ISSUE.
- ISSUE: avg_strobe = 1 for exactly one cycle, then go to WAIT_RESP with the timeout counter at 0.
- WAIT_RESP:
  - On avg_done: register avg_result into m_data, pulse m_valid, increment warm-up count, then go to GAP_WAIT (or IDLE if GAP = 0).
  - If the counter reaches RESP_TIMEOUT without avg_done: set err_timeout, no m_valid, then go to GAP_WAIT.
- GAP_WAIT: hold for GAP cycles, then go to IDLE.
- CLEAR: avg_clear = 1 for CLEAR_CYCLES cycles, and the warm-up count resets to 0. On exit, pulse cfg_ack and go to IDLE.
- Warm-up:
  - The count saturates at 8.
  - m_settled = count ≥ window, where window is 2, 4 or 8 from avg_sel.
  - m_settled is evaluated including the current result, so the window-th m_valid carries m_settled = 1.
- avg_done outside WAIT_RESP is ignored and does not change the count.
- avg_data holds its last value between strobes.

## Timing
- Reset values:
  - State = IDLE, so s_ready = 1 while cfg_req = 0. Upstream must not assert s_valid in reset.
  - All registered outputs = 0: avg_data, avg_strobe, avg_sel = 00 (size 2), avg_clear, m_data, m_valid, m_settled, cfg_ack, cfg_err, err_timeout.
- Acceptance at edge T gives avg_strobe high during T+1.
- avg_done sampled at edge R gives m_valid/m_data high during R+1, which is 1-cycle latency.
- Timeout: with no avg_done by the RESP_TIMEOUT-th WAIT_RESP cycle, err_timeout rises on the next edge.
- cfg_req asserted while busy waits until IDLE and is never dropped. cfg_req and s_valid in the same IDLE cycle: the config wins.
- cfg_ack pulses one cycle after the last avg_clear cycle. The requester must deassert cfg_req on cfg_ack.
- avg_done arriving in the same cycle the timeout expires counts as a response: no error.
- Reset mid-operation aborts any in-flight sample with no m_valid and forces avg_sel to 00.

## Structure
- Shared package ma_ctrl_pkg holds:
  - the state enum
  - filter-select encodings (SEL_2, SEL_4, SEL_8, SEL_BAD)
  - a window-size function sel→{2,4,8}
- Sub-module ma_warmup_tracker: saturating count with clear and increment, compared against the window from avg_sel, producing m_settled.
- Everything else lives in the top FSM.

## Test plan
- Impulse, size 2, averager model with 1-cycle response:
  - Stimulus: 10 zeros, one 1023, then zeros.
  - Required: m_data = 511 on the sample after the impulse and 0 two samples later.
  - Required: m_settled = 1 from the 2nd m_valid.
- Throughput, GAP = 1: continuous s_valid gives one acceptance every 5 cycles with 1-cycle averager latency, and avg_strobe is never high two cycles in a row.
- Reconfig to 10 (size 8) mid-stream:
  - Required: avg_clear high for 2 cycles, then cfg_ack.
  - Required: m_settled low for 7 results and high on the 8th.
- Illegal cfg_sel = 11: cfg_ack and cfg_err pulse together, avg_sel unchanged, and no avg_clear.
- Silent averager: no avg_done, so err_timeout sets 8 cycles into WAIT_RESP, there is no m_valid, and s_ready returns after GAP.
- Reset asserted during WAIT_RESP: all outputs return to their reset values immediately, and a late avg_done after release produces no m_valid.
